// File: rtl/itu656_pkg.sv
// itu656_pkg
//   Shared definitions for the BT.656 transmitter: timing-reference and
//   blanking byte constants, the raster state enum, the XY protection-code
//   builder and the active-video clamp.
package itu656_pkg;

  // Timing reference preamble bytes.
  localparam logic [7:0] TRS_FF   = 8'hFF;
  localparam logic [7:0] TRS_00   = 8'h00;

  // Blanking level: chroma at zero colour, luma at black.
  localparam logic [7:0] BLANK_C  = 8'h80;
  localparam logic [7:0] BLANK_Y  = 8'h10;

  // Active video may never carry the reserved 00/FF codes.
  localparam logic [7:0] CLAMP_LO = 8'h01;
  localparam logic [7:0] CLAMP_HI = 8'hFE;

  // Segment of the line the next output byte belongs to.
  typedef enum logic [1:0] {
    EAV     = 2'd0,
    HBLANK  = 2'd1,
    SAV     = 2'd2,
    PAYLOAD = 2'd3
  } raster_state_t;

  // Fourth byte of a timing reference: 1 F V H P3 P2 P1 P0.
  function automatic logic [7:0] xy_code(input logic f, input logic v, input logic h);
    return {1'b1, f, v, h, v ^ h, f ^ h, f ^ v, f ^ v ^ h};
  endfunction

  // Keep active samples out of the timing-reference code space.
  function automatic logic [7:0] clamp_active(input logic [7:0] b);
    if (b == TRS_00)
      return CLAMP_LO;
    else if (b == TRS_FF)
      return CLAMP_HI;
    else
      return b;
  endfunction

endpackage

// File: rtl/itu656_raster_counter.sv
// itu656_raster_counter
//   Walks the 525-line raster one byte per clock. All outputs describe the
//   byte that the encoder will register onto td_data at the next clock edge.
//
//   Ports:
//     clk, reset : byte clock, synchronous active-high reset
//     f          : F bit of the current line (registered)
//     v          : V bit of the current line (registered, 1 = vertical blank)
//     state      : segment of the line (EAV / HBLANK / SAV / PAYLOAD)
//     offset     : byte offset inside the current segment
//     line       : current line index, 0-based
module itu656_raster_counter
  import itu656_pkg::*;
#(
  parameter int H_ACT         = 720,
  parameter int H_BLANK_BYTES = 268,
  parameter int LINES_TOTAL   = 525,
  parameter int F1_FIRST      = 3,
  parameter int F2_FIRST      = 265,
  parameter int F1_ACT_FIRST  = 19,
  parameter int F1_ACT_LAST   = 262,
  parameter int F2_ACT_FIRST  = 282,
  parameter int F2_ACT_LAST   = 524,
  parameter int BW            = $clog2(8 + H_BLANK_BYTES + 2*H_ACT)
) (
  input  logic          clk,
  input  logic          reset,
  output logic          f,
  output logic          v,
  output raster_state_t state,
  output logic [BW-1:0] offset,
  output logic [9:0]    line
);

  localparam int            LINE_BYTES = 8 + H_BLANK_BYTES + 2*H_ACT;
  localparam logic [BW-1:0] LAST_BYTE  = BW'(LINE_BYTES - 1);
  localparam logic [9:0]    LAST_LINE  = 10'(LINES_TOTAL - 1);

  logic [BW-1:0] byte_cnt;
  logic [BW-1:0] last_off;
  logic [9:0]    line_nxt;
  raster_state_t state_nxt;

  // Field 2 wraps around the frame boundary: it also covers the first
  // few lines of the frame before field 1 starts.
  function automatic logic field_of(input logic [9:0] ln);
    return (ln >= 10'(F2_FIRST)) || (ln < 10'(F1_FIRST));
  endfunction

  function automatic logic vblank_of(input logic [9:0] ln);
    return !(((ln >= 10'(F1_ACT_FIRST)) && (ln <= 10'(F1_ACT_LAST))) ||
             ((ln >= 10'(F2_ACT_FIRST)) && (ln <= 10'(F2_ACT_LAST))));
  endfunction

  always_comb begin
    last_off  = BW'(3);
    state_nxt = HBLANK;
    case (state)
      EAV: begin
        last_off  = BW'(3);
        state_nxt = HBLANK;
      end
      HBLANK: begin
        last_off  = BW'(H_BLANK_BYTES - 1);
        state_nxt = SAV;
      end
      SAV: begin
        last_off  = BW'(3);
        state_nxt = PAYLOAD;
      end
      default: begin
        last_off  = BW'(2*H_ACT - 1);
        state_nxt = EAV;
      end
    endcase
    line_nxt = (line == LAST_LINE) ? 10'd0 : line + 10'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      byte_cnt <= '0;
      offset   <= '0;
      state    <= EAV;
      line     <= 10'd0;
      f        <= field_of(10'd0);
      v        <= vblank_of(10'd0);
    end else begin
      if (offset == last_off) begin
        offset <= '0;
        state  <= state_nxt;
      end else begin
        offset <= offset + BW'(1);
      end

      // F/V are refreshed together with the line index so they always
      // describe the line the next byte belongs to.
      if (byte_cnt == LAST_BYTE) begin
        byte_cnt <= '0;
        line     <= line_nxt;
        f        <= field_of(line_nxt);
        v        <= vblank_of(line_nxt);
      end else begin
        byte_cnt <= byte_cnt + BW'(1);
      end
    end
  end

endmodule

// File: rtl/itu656_encoder.sv
// itu656_encoder
//   BT.656 transmitter. Converts a 4:2:2 YCbCr word stream into the 8-bit
//   27 MHz byte stream with EAV/SAV timing references and blanking payload.
//
//   Ports:
//     clk, reset  : byte clock, synchronous active-high reset
//     pix_data    : [15:8] Y, [7:0] C (Cb on even pixel, Cr on odd)
//     pix_valid   : pix_data holds a word
//     pix_ready   : word is taken this cycle if pix_valid (registered)
//     td_data     : BT.656 byte stream (registered)
//     field       : F bit of the line being transmitted
//     line_cnt    : index of the line being transmitted
//     frame_start : pulse with the first EAV byte of line 0
//     underflow   : pulse with a C byte that had to be replaced by black
module itu656_encoder
  import itu656_pkg::*;
#(
  parameter int H_ACT         = 720,
  parameter int H_BLANK_BYTES = 268,
  parameter int LINES_TOTAL   = 525,
  parameter int F1_FIRST      = 3,
  parameter int F2_FIRST      = 265,
  parameter int F1_ACT_FIRST  = 19,
  parameter int F1_ACT_LAST   = 262,
  parameter int F2_ACT_FIRST  = 282,
  parameter int F2_ACT_LAST   = 524
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] pix_data,
  input  logic        pix_valid,
  output logic        pix_ready,
  output logic [7:0]  td_data,
  output logic        field,
  output logic [9:0]  line_cnt,
  output logic        frame_start,
  output logic        underflow
);

  localparam int            OW       = $clog2(8 + H_BLANK_BYTES + 2*H_ACT);
  localparam logic [OW-1:0] LAST_PAY = OW'(2*H_ACT - 1);

  logic          rc_f;
  logic          rc_v;
  raster_state_t rc_state;
  logic [OW-1:0] rc_off;
  logic [9:0]    rc_line;

  logic [7:0]    y_hold;
  logic [7:0]    byte_nxt;
  logic          ready_nxt;
  logic          first_eav;

  itu656_raster_counter #(
    .H_ACT         (H_ACT),
    .H_BLANK_BYTES (H_BLANK_BYTES),
    .LINES_TOTAL   (LINES_TOTAL),
    .F1_FIRST      (F1_FIRST),
    .F2_FIRST      (F2_FIRST),
    .F1_ACT_FIRST  (F1_ACT_FIRST),
    .F1_ACT_LAST   (F1_ACT_LAST),
    .F2_ACT_FIRST  (F2_ACT_FIRST),
    .F2_ACT_LAST   (F2_ACT_LAST),
    .BW            (OW)
  ) u_raster (
    .clk    (clk),
    .reset  (reset),
    .f      (rc_f),
    .v      (rc_v),
    .state  (rc_state),
    .offset (rc_off),
    .line   (rc_line)
  );

  assign first_eav = (rc_state == EAV) && (rc_off == '0);

  // pix_ready is registered, so it is raised while the counter sits on the
  // byte just before an active C byte: the last SAV byte or any Y byte
  // except the final one of the line.
  assign ready_nxt = !rc_v &&
                     (((rc_state == SAV) && (rc_off == OW'(3))) ||
                      ((rc_state == PAYLOAD) && rc_off[0] && (rc_off != LAST_PAY)));

  always_comb begin
    byte_nxt = BLANK_C;
    case (rc_state)
      EAV, SAV: begin
        case (rc_off[1:0])
          2'd0:    byte_nxt = TRS_FF;
          2'd3:    byte_nxt = xy_code(rc_f, rc_v, rc_state == EAV);
          default: byte_nxt = TRS_00;
        endcase
      end
      HBLANK: byte_nxt = rc_off[0] ? BLANK_Y : BLANK_C;
      default: begin
        if (rc_v)
          byte_nxt = rc_off[0] ? BLANK_Y : BLANK_C;
        else if (rc_off[0])
          byte_nxt = y_hold;
        else if (pix_ready && pix_valid)
          byte_nxt = clamp_active(pix_data[7:0]);
        else
          byte_nxt = BLANK_C;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      td_data     <= BLANK_Y;
      pix_ready   <= 1'b0;
      frame_start <= 1'b0;
      underflow   <= 1'b0;
      field       <= 1'b1;
      line_cnt    <= 10'd0;
      y_hold      <= BLANK_Y;
    end else begin
      td_data     <= byte_nxt;
      pix_ready   <= ready_nxt;
      frame_start <= first_eav && (rc_line == 10'd0);
      underflow   <= pix_ready && !pix_valid;
      if (first_eav) begin
        field    <= rc_f;
        line_cnt <= rc_line;
      end
      // C goes straight out on the capture edge; Y waits one byte here.
      if (pix_ready)
        y_hold <= pix_valid ? clamp_active(pix_data[15:8]) : BLANK_Y;
    end
  end

endmodule

// File: tb/tb_itu656_encoder.sv
// tb_itu656_encoder
//   Directed bench. A full-size encoder is checked byte by byte on a
//   blanking line and two active lines (one with a dropped pixel), then
//   reset mid-line. A shrunken-line encoder (same line numbering) covers
//   the field-2 timing codes and the frame period within a short run.
module tb_itu656_encoder;

  localparam int LINE   = 1716;
  localparam int S_LINE = 24;
  localparam int S_FRAME = 525 * S_LINE;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] pix_data = 16'h0;
  logic        pix_valid = 1'b0;
  logic        pix_ready;
  logic [7:0]  td_data;
  logic        field;
  logic [9:0]  line_cnt;
  logic        frame_start;
  logic        underflow;

  logic        s_reset = 1'b1;
  logic [15:0] s_pix_data = 16'h0;
  logic        s_pix_valid = 1'b0;
  logic        s_pix_ready;
  logic [7:0]  s_td;
  logic        s_field;
  logic [9:0]  s_line_cnt;
  logic        s_frame_start;
  logic        s_underflow;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  itu656_encoder u_dut (
    .clk         (clk),
    .reset       (reset),
    .pix_data    (pix_data),
    .pix_valid   (pix_valid),
    .pix_ready   (pix_ready),
    .td_data     (td_data),
    .field       (field),
    .line_cnt    (line_cnt),
    .frame_start (frame_start),
    .underflow   (underflow)
  );

  itu656_encoder #(.H_ACT(4), .H_BLANK_BYTES(8)) u_small (
    .clk         (clk),
    .reset       (s_reset),
    .pix_data    (s_pix_data),
    .pix_valid   (s_pix_valid),
    .pix_ready   (s_pix_ready),
    .td_data     (s_td),
    .field       (s_field),
    .line_cnt    (s_line_cnt),
    .frame_start (s_frame_start),
    .underflow   (s_underflow)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, got, want);
    end
  endtask

  function automatic logic [7:0] clampb(input logic [7:0] x);
    if (x == 8'h00) return 8'h01;
    if (x == 8'hFF) return 8'hFE;
    return x;
  endfunction

  // One full line, starting with the counter on byte 0 of line ln.
  task automatic run_line(input int ln, input logic [7:0] eav_xy, input logic [7:0] sav_xy,
                          input logic fexp, input bit act, input int drop_k);
    int hs, uf, o, k;
    bit c_pos;
    logic [7:0] e;
    hs = 0;
    uf = 0;
    for (int b = 0; b < LINE; b++) begin
      o = b - 276;
      k = (b >= 276) ? o / 2 : 0;
      c_pos = act && (b >= 276) && (o % 2 == 0);
      chk("pix_ready", {31'd0, pix_ready}, {31'd0, c_pos});
      pix_valid = act && !(c_pos && k == drop_k);
      pix_data  = c_pos ? {8'(k), 8'(64 + k)} : 16'h0;
      if (pix_valid && pix_ready) hs++;
      step();
      if (b < 4 || (b >= 272 && b < 276)) begin
        case ((b < 4) ? b : b - 272)
          0:       e = 8'hFF;
          3:       e = (b < 4) ? eav_xy : sav_xy;
          default: e = 8'h00;
        endcase
      end else if (!act || b < 276) begin
        e = (b % 2 == 0) ? 8'h80 : 8'h10;
      end else if (k == drop_k) begin
        e = (o % 2 == 0) ? 8'h80 : 8'h10;
      end else begin
        e = clampb((o % 2 == 0) ? 8'(64 + k) : 8'(k));
      end
      chk("td_data", {24'd0, td_data}, {24'd0, e});
      chk("underflow", {31'd0, underflow}, {31'd0, (c_pos && k == drop_k)});
      chk("frame_start", {31'd0, frame_start}, {31'd0, (ln == 0 && b == 0)});
      if (b == 0) begin
        chk("line_cnt", {22'd0, line_cnt}, 32'(ln));
        chk("field", {31'd0, field}, {31'd0, fexp});
      end
      if (underflow) uf++;
    end
    pix_valid = 1'b0;
    chk("handshakes", 32'(hs), act ? ((drop_k >= 0) ? 32'd719 : 32'd720) : 32'd0);
    chk("underflow_count", 32'(uf), (drop_k >= 0) ? 32'd1 : 32'd0);
  endtask

  initial begin
    int pulses, last_fs, p, ln, b;

    // Reset state
    repeat (3) step();
    chk("rst_td", {24'd0, td_data}, 32'h10);
    chk("rst_ready", {31'd0, pix_ready}, 32'd0);
    chk("rst_fs", {31'd0, frame_start}, 32'd0);
    chk("rst_uf", {31'd0, underflow}, 32'd0);
    chk("rst_field", {31'd0, field}, 32'd1);
    chk("rst_line", {22'd0, line_cnt}, 32'd0);
    reset = 1'b0;

    // Line 0: vertical blanking, nothing requested.
    run_line(0, 8'hF1, 8'hEC, 1'b1, 1'b0, -1);
    repeat (18 * LINE) step();

    // Line 19: first active line of field 1, counting data (exercises clamp).
    run_line(19, 8'h9D, 8'h80, 1'b0, 1'b1, -1);
    // Line 20: pixel 5 missing.
    run_line(20, 8'h9D, 8'h80, 1'b0, 1'b1, 5);

    // Line 21: reset in the middle of active video.
    pix_valid = 1'b1;
    pix_data  = 16'h5566;
    repeat (900) step();
    chk("pre_rst_ready", {31'd0, pix_ready}, 32'd1);
    reset = 1'b1;
    step();
    chk("midrst_td", {24'd0, td_data}, 32'h10);
    chk("midrst_ready", {31'd0, pix_ready}, 32'd0);
    chk("midrst_line", {22'd0, line_cnt}, 32'd0);
    chk("midrst_field", {31'd0, field}, 32'd1);
    reset = 1'b0;
    pix_valid = 1'b0;
    step();
    chk("post_rst_td", {24'd0, td_data}, 32'hFF);
    chk("post_rst_fs", {31'd0, frame_start}, 32'd1);
    chk("post_rst_line", {22'd0, line_cnt}, 32'd0);

    // Short-line encoder: field-2 codes and frame period.
    s_reset = 1'b0;
    pulses = 0;
    last_fs = 0;
    for (int n = 1; n <= S_FRAME + 1; n++) begin
      step();
      p  = n - 1;
      ln = p / S_LINE;
      b  = p % S_LINE;
      if (n == 1) chk("s_first_td", {24'd0, s_td}, 32'hFF);
      if (s_frame_start) begin
        pulses++;
        if (pulses == 1) chk("s_fs_first", 32'(n), 32'd1);
        else             chk("s_fs_period", 32'(n - last_fs), 32'(S_FRAME));
        last_fs = n;
      end
      if (ln == 263 && b == 3)  chk("l263_eav", {24'd0, s_td}, 32'hB6);
      if (ln == 263 && b == 15) chk("l263_sav", {24'd0, s_td}, 32'hAB);
      if (ln == 265 && b == 3)  chk("l265_eav", {24'd0, s_td}, 32'hF1);
      if (ln == 265 && b == 15) chk("l265_sav", {24'd0, s_td}, 32'hEC);
      if (ln == 282 && b == 0)  chk("l282_field", {31'd0, s_field}, 32'd1);
      if (ln == 282 && b == 3)  chk("l282_eav", {24'd0, s_td}, 32'hDA);
      if (ln == 282 && b == 12) chk("l282_sav_ff", {24'd0, s_td}, 32'hFF);
      if (ln == 282 && b == 15) chk("l282_sav", {24'd0, s_td}, 32'hC7);
    end
    chk("s_fs_pulses", 32'(pulses), 32'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/itu656_encoder.md
Name: itu656_encoder

Overview:
- ITU-R BT.656 transmitter and the inverse of the capture path's 656 decoder. Turns a YCbCr 4:2:2 pixel stream, for example read back from the SDRAM frame buffer, into an 8-bit 27 MHz NTSC byte stream.
- Generates the raster, EAV/SAV timing codes with F/V/H bits and protection bits, and horizontal/vertical blanking payload.
- Pulls pixels from upstream with a ready/valid handshake.
- Feeds a video DAC/encoder or a loopback into the capture path.

Parameters:
H_ACT, 720, active luma samples per line (even)
H_BLANK_BYTES, 268, blanking payload bytes between EAV and SAV (even)
LINES_TOTAL, 525, lines per frame (line index 0-based)
F1_FIRST, 3, first line of field 1 (F=0)
F2_FIRST, 265, first line of field 2 (F=1); F=1 when line>=F2_FIRST or line<F1_FIRST
F1_ACT_FIRST, 19, first active line of field 1
F1_ACT_LAST, 262, last active line of field 1
F2_ACT_FIRST, 282, first active line of field 2
F2_ACT_LAST, 524, last active line of field 2

Ports:
clk  in  1  27 MHz byte clock
reset  in  1  synchronous, active-high
pix_data  in  16  [15:8]=Y, [7:0]=C; C is Cb on even pixel, Cr on odd
pix_valid  in  1  pix_data valid
pix_ready  out  1  encoder takes pix_data this cycle if pix_valid
td_data  out  8  BT.656 byte stream, registered
field  out  1  current F bit
line_cnt  out  10  current line index
frame_start  out  1  one-cycle pulse coincident with first EAV byte of line 0
underflow  out  1  one-cycle pulse when a pixel was needed but pix_valid=0

Interface decisions:
- One clock: clk.
- Reset is synchronous and active-high: reset.

Behaviour:
- Line length is 4 + H_BLANK_BYTES + 4 + 2*H_ACT bytes (1716 by default). byte_cnt runs 0..1715 and wraps, incrementing line_cnt; line_cnt wraps at LINES_TOTAL-1 back to 0.
- States, on the byte being presented: EAV (4 bytes), HBLANK (H_BLANK_BYTES), SAV (4), PAYLOAD (2*H_ACT). Transition EAV→HBLANK→SAV→PAYLOAD→EAV on each state's last byte.
- Timing code: FF, 00, 00, XY, with XY = {1,F,V,H,V^H,F^H,F^V,F^V^H}. H=1 for EAV, 0 for SAV.
- V=0 only on lines in [F1_ACT_FIRST,F1_ACT_LAST] or [F2_ACT_FIRST,F2_ACT_LAST]. F and V are evaluated on the line of the code byte.
- HBLANK payload, and PAYLOAD on V=1 lines: alternating 0x80, 0x10, starting with 0x80.
- Active PAYLOAD, pixel k: bytes C_k, Y_k, in the order Cb0 Y0 Cr0 Y1 …
- Handshake:
  - pix_ready is registered and high exactly one cycle before each active C byte appears on td_data, so one cycle in two.
  - The word is captured when pix_valid&&pix_ready. C is output next cycle, Y the cycle after.
  - Exactly H_ACT words are consumed per active line; none on blanking lines.
  - pix_ready does not depend on pix_valid.
- Underflow: if pix_ready=1 and pix_valid=0, output black (C=0x80, Y=0x10) for that pixel and pulse underflow with the C byte. The raster never stalls.
- Data clamp: active bytes 0x00 become 0x01, and 0xFF becomes 0xFE. Timing codes are never clamped.
- Latency: 1 cycle from capture to C byte.
- Reset values: td_data=0x10, pix_ready=0, frame_start=0, underflow=0, field=1, line_cnt=0, byte_cnt=0, state=EAV.
- First cycle after reset deasserts: td_data=0xFF, frame_start=1.
- Reset mid-line: immediate return to the reset state. A partially consumed word is discarded; upstream must reset its source too.
- field and line_cnt update together with the first EAV byte of each line.

Decomposition:
- itu656_pkg holds:
  - constants TRS_FF=8'hFF, TRS_00=8'h00, BLANK_C=8'h80, BLANK_Y=8'h10, CLAMP_LO=8'h01, CLAMP_HI=8'hFE
  - state enum {EAV, HBLANK, SAV, PAYLOAD}
  - an XY-code function of (F,V,H)
- Sub-module itu656_raster_counter:
  - contains byte_cnt, line_cnt, state, and F/V decode
  - outputs the registered F, V, state, and offset within state
- The top level contains the handshake, byte mux, clamp and pulses.

Test Plan:
- Reset, then run 1716 cycles with pix_valid=0 → bytes 0..3 are FF 00 00 F1; bytes 272..275 are FF 00 00 EC; all other bytes alternate 80/10; pix_ready never high; frame_start at cycle 0 only.
- Line 19, pix_valid=1 with counting data Y=k, C=0x40+k → EAV XY=9D, SAV XY=80; 720 handshakes; output sequence 40 00 41 01 … (with 0x00 clamped to 01) per pixel order.
- Line 282 → EAV XY=DA, SAV XY=C7. Line 265 (blanking) → F1/EC. Line 263 → B6/AB. Exactly 900900 cycles between frame_start pulses.
- Drop pix_valid for pixel 5 on an active line → bytes 80 10 for that pixel, one underflow pulse, and subsequent pixels aligned.
- Pixel Y=0xFF, C=0x00 → output bytes 01 FE. A timing-code FF on the same line is unaffected.
- Assert reset at byte 900 of line 100 → next cycle td_data=0x10, pix_ready=0; after release td_data=FF, line_cnt=0.
